// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction-fetch
// port and a load/store port, with registered acknowledge and a completion timeout.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_ack,
    output logic [DW-1:0]     i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [AW-1:0]     d_addr,
    input  logic              d_we,
    input  logic [DW/8-1:0]   d_be,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_prio_d;
    logic          r_owner_d;
    logic [CW-1:0] r_cnt;
    logic          w_grant;
    logic          w_grant_d;
    logic          w_done;
    logic          w_timeout;

    // Next-state and per-cycle decisions
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_grant     = 1'b1;
                    w_grant_d   = d_req && (!i_req || r_prio_d);
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // mem_ready wins over a timeout landing in the same cycle
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_done      = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration bookkeeping and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_d  <= 1'b1;
            r_owner_d <= 1'b0;
            r_cnt     <= '0;
        end else if (w_grant) begin
            r_prio_d  <= !w_grant_d;
            r_owner_d <= w_grant_d;
            r_cnt     <= '0;
        end else if (r_state == S_BUSY && !w_done && r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Memory-side request, latched at grant and held through BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                mem_req <= 1'b1;
                if (w_grant_d) begin
                    mem_addr  <= d_addr;
                    mem_we    <= d_we;
                    mem_be    <= d_be;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr  <= i_addr;
                    mem_we    <= 1'b0;
                    mem_be    <= {BW{1'b1}};
                    mem_wdata <= '0;
                end
            end else if (w_done) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Requester-side completion; stores and timeouts return zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ack   <= 1'b0;
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (w_done) begin
                if (r_owner_d) begin
                    d_ack   <= 1'b1;
                    d_err   <= w_timeout;
                    d_rdata <= (w_timeout || mem_we) ? '0 : mem_rdata;
                end else begin
                    i_ack   <= 1'b1;
                    i_err   <= w_timeout;
                    i_rdata <= w_timeout ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a behavioural memory and
// round-robin model predict every acknowledge and the latched bus fields.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned TO = 4;

    typedef struct {
        bit          port_d;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        bit          err;
    } txn_t;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    txn_t exp_q[$];
    logic [31:0] ref_mem  [16];
    logic [31:0] phys_mem [16];
    bit   prio_d;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic give_up(input string name);
        n_checks++;
        $display("FAIL %s: DUT did not respond within the cycle budget", name);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic txn_t make_i(input int lat, input bit fix_addr, input logic [31:0] addr);
        txn_t t;
        t.port_d = 1'b0;
        t.addr   = fix_addr ? addr : $urandom;
        t.we     = 1'b0;
        t.be     = 4'hF;
        t.wdata  = 32'h0;
        t.lat    = (lat == 0) ? int'($urandom_range(1, TO + 1)) : lat;
        t.rdata  = 32'h0;
        t.err    = 1'b0;
        return t;
    endfunction

    // mode: 0 random, 1 store, 2 load
    function automatic txn_t make_d(input int lat, input int mode);
        txn_t t;
        t.port_d = 1'b1;
        t.addr   = $urandom;
        t.we     = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        t.be     = 4'($urandom_range(1, 15));
        t.wdata  = $urandom;
        t.lat    = (lat == 0) ? int'($urandom_range(1, TO + 1)) : lat;
        t.rdata  = 32'h0;
        t.err    = 1'b0;
        return t;
    endfunction

    // Reference outcome of a transaction, applied to the model memory in grant order
    function automatic txn_t resolve(input txn_t t);
        txn_t r;
        int   idx;
        r   = t;
        idx = int'(t.addr[5:2]);
        if (t.lat > int'(TO)) begin
            r.err   = 1'b1;
            r.rdata = 32'h0;
        end else if (t.we) begin
            ref_mem[idx] = merge(ref_mem[idx], t.wdata, t.be);
            r.rdata = 32'h0;
        end else begin
            r.rdata = ref_mem[idx];
        end
        return r;
    endfunction

    task automatic drive(input txn_t t);
        if (t.port_d) begin
            d_req = 1'b1; d_addr = t.addr; d_we = t.we; d_be = t.be; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
    endtask

    // Follow one granted transaction to its ack, perturbing the owner's inputs meanwhile
    task automatic serve(input bit pd, input int lat);
        int g;
        int c;
        int exp_l;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (g > 10) give_up("grant_wait");
        end while (mem_req !== 1'b1);
        if (pd) begin
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        end else begin
            i_addr = $urandom;
        end
        c = 1;
        forever begin
            @(negedge clk);
            if ((pd ? d_ack : i_ack) === 1'b1) break;
            c++;
            if (c > int'(TO) + 3) give_up("ack_wait");
        end
        exp_l = (lat > int'(TO)) ? int'(TO) : lat;
        check("latency", 32'(c), 32'(exp_l));
        if (pd) d_req = 1'b0;
        else    i_req = 1'b0;
    endtask

    task automatic run_round(input bit want_i, input bit want_d, input txn_t ti, input txn_t td);
        txn_t ord[2];
        int   n;
        if (want_i && want_d) begin
            if (prio_d) begin ord[0] = td; ord[1] = ti; end
            else        begin ord[0] = ti; ord[1] = td; end
            n = 2;
        end else if (want_d) begin
            ord[0] = td; n = 1; prio_d = 1'b0;
        end else begin
            ord[0] = ti; n = 1; prio_d = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            ord[k] = resolve(ord[k]);
            exp_q.push_back(ord[k]);
        end
        if (want_i) drive(ti);
        if (want_d) drive(td);
        for (int k = 0; k < n; k++) serve(ord[k].port_d, ord[k].lat);
    endtask

    // Memory responder: completes after the planned number of BUSY cycles
    initial begin
        int   bc;
        txn_t t;
        bc = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !rst && exp_q.size() > 0) begin
                bc++;
                t = exp_q[0];
                check("mem_addr", mem_addr, t.addr);
                check("mem_we", 32'(mem_we), 32'(t.we));
                check("mem_be", 32'(mem_be), 32'(t.be));
                if (t.we || !t.port_d) check("mem_wdata", mem_wdata, t.wdata);
                if (bc == t.lat) begin
                    mem_ready = 1'b1;
                    if (t.we) begin
                        phys_mem[mem_addr[5:2]] = merge(phys_mem[mem_addr[5:2]], mem_wdata, mem_be);
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = phys_mem[mem_addr[5:2]];
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                bc = 0;
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: every acknowledge is matched against the scoreboard head
    initial begin
        bit   prev;
        txn_t t;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (i_ack === 1'b1 || d_ack === 1'b1)) begin
                if (prev) check("ack_single_cycle", 32'(1), 32'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {30'b0, d_ack, i_ack}, 32'(0));
                end else begin
                    t = exp_q.pop_front();
                    check("ack_port", {30'b0, d_ack, i_ack}, t.port_d ? 32'(2) : 32'(1));
                    check("rdata", t.port_d ? d_rdata : i_rdata, t.rdata);
                    check("err", 32'(t.port_d ? d_err : i_err), 32'(t.err));
                    check("mem_req_in_resp", 32'(mem_req), 32'(0));
                    check("busy_in_resp", 32'(busy), 32'(1));
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
    end

    initial begin
        txn_t ti;
        txn_t td;
        bit   wi;
        bit   wd;
        logic [31:0] v;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
        prio_d = 1'b1;
        for (int k = 0; k < 16; k++) begin
            v = $urandom;
            ref_mem[k]  = v;
            phys_mem[k] = v;
        end
        ref_mem[0]  = 32'h12345678;
        phys_mem[0] = 32'h12345678;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_acks", {30'b0, d_ack, i_ack}, 32'(0));
        check("rst_mem_be", 32'(mem_be), 32'(0));
        check("rst_mem_addr", mem_addr, 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Fetch from 0x100 with zero-wait memory
        run_round(1'b1, 1'b0, make_i(1, 1'b1, 32'h100), make_d(0, 0));
        // Simultaneous requests: data first, then fetch
        run_round(1'b1, 1'b1, make_i(0, 1'b0, 32'h0), make_d(0, 0));
        run_round(1'b1, 1'b1, make_i(0, 1'b0, 32'h0), make_d(0, 0));
        // Store with 3-cycle memory
        run_round(1'b0, 1'b1, make_i(0, 1'b0, 32'h0), make_d(3, 1));
        // Timeout followed by a normal fetch
        run_round(1'b0, 1'b1, make_i(0, 1'b0, 32'h0), make_d(int'(TO) + 1, 2));
        run_round(1'b1, 1'b0, make_i(1, 1'b0, 32'h0), make_d(0, 0));
        // Completion on the last allowed cycle
        run_round(1'b1, 1'b0, make_i(int'(TO), 1'b0, 32'h0), make_d(0, 0));
        run_round(1'b0, 1'b1, make_i(0, 1'b0, 32'h0), make_d(int'(TO), 2));

        for (int r = 0; r < 150; r++) begin
            wi = 1'($urandom);
            wd = 1'($urandom);
            if (!wi && !wd) wd = 1'b1;
            run_round(wi, wd, make_i(0, 1'b0, 32'h0), make_d(0, 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a transaction
        td = make_d(int'(TO) + 1, 2);
        exp_q.push_back(td);
        drive(td);
        for (int g = 0; mem_req !== 1'b1; g++) begin
            @(negedge clk);
            if (g > 10) give_up("grant_before_reset");
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_d_ack", 32'(d_ack), 32'(0));
        check("midrst_mem_be", 32'(mem_be), 32'(0));
        exp_q.delete();
        d_req = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        prio_d = 1'b1;
        @(negedge clk);
        ti = make_i(0, 1'b0, 32'h0);
        td = make_d(0, 0);
        run_round(1'b1, 1'b1, ti, td);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one unified single-port memory between the CPU instruction-fetch port and the load/store data port. It sits between the core datapath and the memory model or bus. It serialises requests with a round-robin pointer and holds each transaction until the memory signals completion. It also returns a registered acknowledge, and raises a bus error if the memory does not complete within a cycle budget.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width; DW/8 byte enables
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready; must be ≥1
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DW  fetch data, valid while i_ack=1
- i_err  out  1  fetch timed out, valid while i_ack=1
- d_req  in  1  data request, held until d_ack
- d_addr  in  AW  data address
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid while d_ack=1
- d_err  out  1  data timed out, valid while d_ack=1
- mem_req  out  1  transaction active, held until completion
- mem_addr  out  AW  latched address
- mem_we  out  1  latched write enable; always 0 for fetch
- mem_be  out  DW/8  latched byte enables; all ones for fetch
- mem_wdata  out  DW  latched store data; 0 for fetch
- mem_rdata  in  DW  read data, sampled with mem_ready
- mem_ready  in  1  one-cycle completion from memory
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BUSY and RESP. Reset enters IDLE.
- IDLE, no request: remain in IDLE.
- IDLE, exactly one request: grant that port.
- IDLE, both requests: grant the port selected by the priority pointer.
  - After reset the pointer favours the data port.
  - After each grant the pointer favours the other port.
- On grant:
  - Latch the transaction into mem_addr, mem_we, mem_be and mem_wdata.
  - Record the owner port.
  - Clear the wait counter.
  - Go to BUSY.
- BUSY, mem_ready=1:
  - Latch mem_rdata into the owner's rdata.
  - Set the owner's ack=1 and err=0.
  - Go to RESP.
- BUSY, mem_ready=0 and counter==TIMEOUT-1:
  - Set the owner's ack=1 and err=1, with rdata=0.
  - Go to RESP.
- BUSY, otherwise: increment the counter and stay in BUSY.
- If mem_ready and the timeout coincide, the normal completion (mem_ready) takes precedence.
- RESP:
  - ack is high for this one cycle.
  - No grant is made.
  - Go to IDLE.
  - Requesters may drop or change req from the next cycle.
- mem_ready is ignored outside BUSY.
- Request inputs are not sampled outside IDLE. The non-granted port keeps waiting, and its req stays high.
- Stores ignore mem_rdata; the ack signals write completion and d_rdata=0.
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset asserted mid-transaction:
  - The transaction is abandoned.
  - All outputs are forced to reset values immediately.
  - No ack is generated for the abandoned transaction.

## Timing
- All outputs are registered. Reset value of every output is 0, including mem_be=0 and busy=0.
- mem_req rises the cycle after the request is seen in IDLE. It stays high through every BUSY cycle and falls entering RESP.
- Per-transaction latency, counted from req sampled to ack high: L+1 cycles, where L is the number of BUSY cycles up to and including the mem_ready cycle.
  - Zero-wait memory (mem_ready in the first BUSY cycle): ack appears 2 cycles after req is sampled.
- Minimum spacing between grants is L+2 cycles: IDLE, then BUSY×L, then RESP.
- Timeout: ack+err appears TIMEOUT+1 cycles after the grant cycle.
- mem_addr, mem_we, mem_be and mem_wdata stay constant throughout BUSY, even if the requester's inputs change.

## Test plan
- Fetch with 1-cycle memory:
  - Stimulus: i_addr=0x100, mem_ready in first BUSY cycle with mem_rdata=0x12345678.
  - Response: i_ack for exactly 1 cycle with i_rdata=0x12345678, i_err=0; mem_we=0 and mem_be=0xF during BUSY.
- Simultaneous requests after reset:
  - Stimulus: i_req and d_req high together.
  - Response: data port is granted first, fetch is granted next. With both held continuously, grants alternate D,I,D,I.
- Store with 3-cycle memory:
  - Stimulus: d_we=1, d_be=0x3, d_wdata=0xCAFEBABE; d_wdata changes mid-BUSY.
  - Response: mem_wdata stays 0xCAFEBABE; d_ack arrives 4 cycles after req, with d_rdata=0.
- Timeout with TIMEOUT=4:
  - Stimulus: mem_ready is never asserted.
  - Response: d_ack=1 with d_err=1 and d_rdata=0, arriving 5 cycles after the grant cycle; mem_req drops; a following fetch completes normally.
- Coincident completion:
  - Stimulus: mem_ready=1 in the cycle where counter==TIMEOUT-1.
  - Response: ack with err=0 and the correct rdata.
- Reset mid-BUSY:
  - Stimulus: assert rst asynchronously during BUSY.
  - Response: mem_req, busy and ack drop immediately; after release, a new request is served with the data port favoured.
